stack_alu_sequencer: RTL and testbench
======================================

// Module: stack_alu_sequencer
// PURPOSE
//  Operand data stack and sequencer that drives the 8-bit stack-machine ALU.
//  Accepts push/pop/ALU commands, presents TOS/NOS as a/b with fn_sel/arg_cnt,
//  and writes the ALU result back as the new TOS. The ALU is instantiated
//  outside this block; this block is the other end of the ALU interface.
// PARAMETERS
//  W      8   data width; must equal the ALU width
//  DEPTH  16  total stack entries: TOS register plus DEPTH-1 RAM words (min 2)
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      high in IDLE only; accept = cmd_valid & cmd_ready
//  cmd_op       in   3      000 CLR_ERR, 001 PUSH, 010 POP, 011 ALU, 100 DUP (macro), others NOP
//  cmd_data     in   W      PUSH operand
//  cmd_fn       in   3      ALU function select, passed to ALU
//  cmd_arg_cnt  in   1      1 = binary (a=NOS, b=TOS), 0 = unary (a=TOS)
//  alu_a        out  W      ALU operand a
//  alu_b        out  W      ALU operand b
//  alu_fn_sel   out  3      ALU function select
//  alu_arg_cnt  out  1      ALU arity
//  alu_q        in   W      ALU result (combinational)
//  tos          out  W      current top of stack
//  depth        out  $clog2(DEPTH+1)  valid entries, 0..DEPTH
//  empty/full   out  1      depth==0 / depth==DEPTH
//  pop_valid    out  1      one-cycle pulse, pop_data valid
//  pop_data     out  W      popped value
//  err_ovf      out  1      sticky overflow
//  err_unf      out  1      sticky underflow
// BEHAVIOUR
//  - Reset: state IDLE, depth=0, tos=0, pop_valid=0, pop_data=0, err_*=0; RAM not cleared.
//  - Storage: RAM entry i = i-th word below TOS from bottom; NOS = ram[depth-2].
//    RAM read is synchronous (address registered at accept edge, data next cycle).
//  - FSM: IDLE, LOAD. Accept edge N is in IDLE.
//  - PUSH: if full -> err_ovf=1, no change. Else ram[depth-1]<=tos (if depth>0),
//    tos<=cmd_data, depth++. Completes at edge N; stays IDLE.
//  - DUP: as PUSH with cmd_data replaced by tos; depth==0 -> err_unf, no change.
//  - POP: depth==0 -> err_unf, no pulse. Else pop_data<=tos, pop_valid=1 in cycle
//    N+1, depth--. depth==1: stays IDLE, tos unchanged. depth>=2: -> LOAD, tos<=ram
//    read data at edge N+1, -> IDLE.
//  - ALU unary (arg_cnt=0): depth==0 -> err_unf. Else tos<=alu_q at edge N.
//  - ALU binary: depth<2 -> err_unf, no change. Else op latched, -> LOAD;
//    in LOAD alu_a=ram data, alu_b=tos; tos<=alu_q, depth-- at edge N+1; -> IDLE.
//  - ALU drive: IDLE: alu_a=tos, alu_b=tos, fn/arg_cnt=cmd_fn/cmd_arg_cnt;
//    LOAD: fn/arg_cnt = latched values. Combinational outputs.
//  - cmd_ready=0 in LOAD; max one LOAD cycle per command; throughput 1/cycle
//    for single-cycle ops, 1 per 2 cycles otherwise.
//  - Errors are sticky; cleared only by CLR_ERR (edge N) or rst. A faulting
//    command is consumed (ready handshake completes) with no state change.
//  - rst in LOAD: pending op discarded, reset values apply at that edge.
//  - depth counts no wrap: never exceeds DEPTH, never below 0.
// CONFIGURATION
//  STACK_DUP_EN defined: cmd_op 100 = DUP as above.
//  Undefined: 100 is NOP (accepted, no state/flag change), no DUP logic built.
// TESTING
//  - rst then PUSH 8'h05, PUSH 8'h03, ALU fn=1 arg=1 -> tos=8'h02, depth=1, ready low 1 cycle.
//  - PUSH 8'hF0, ALU fn=x arg=0 with ALU model -> tos=alu_q at accept edge, depth unchanged.
//  - PUSH 8'hAA, PUSH 8'hBB, POP -> pop_valid pulse, pop_data=8'hBB, tos=8'hAA, depth=1.
//  - DEPTH pushes then PUSH 8'h11 -> err_ovf=1, full=1, tos unchanged; CLR_ERR -> err_ovf=0.
//  - empty: POP and binary ALU with depth=1 -> err_unf=1, no pop_valid, tos/depth unchanged.
//  - rst asserted in LOAD of binary ALU -> next cycle depth=0, tos=0, IDLE, cmd_ready=1.

Source files
------------

// File: rtl/stack_alu_sequencer.sv
// ============================================================================
// Module     : stack_alu_sequencer
// Description: Operand stack and sequencer for an external 8-bit stack ALU.
//              Optional DUP command is built when STACK_DUP_EN is defined.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module stack_alu_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_op_i,
  input  logic [W-1:0]               cmd_data_i,
  input  logic [2:0]                 cmd_fn_i,
  input  logic                       cmd_arg_cnt_i,
  output logic [W-1:0]               alu_a_o,
  output logic [W-1:0]               alu_b_o,
  output logic [2:0]                 alu_fn_sel_o,
  output logic                       alu_arg_cnt_o,
  input  logic [W-1:0]               alu_q_i,
  output logic [W-1:0]               tos_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       pop_valid_o,
  output logic [W-1:0]               pop_data_o,
  output logic                       err_ovf_o,
  output logic                       err_unf_o
);

  localparam int c_dw = $clog2(DEPTH + 1);
  localparam int c_rw = DEPTH - 1;
  localparam int c_aw = (c_rw > 1) ? $clog2(c_rw) : 1;
  localparam logic [c_dw-1:0] c_full = c_dw'(DEPTH);

  localparam logic [2:0] c_op_clr  = 3'b000;
  localparam logic [2:0] c_op_push = 3'b001;
  localparam logic [2:0] c_op_pop  = 3'b010;
  localparam logic [2:0] c_op_alu  = 3'b011;
`ifdef STACK_DUP_EN
  localparam logic [2:0] c_op_dup  = 3'b100;
`endif

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [c_dw-1:0] depth_q, depth_d;
  logic [W-1:0]    tos_q, tos_d;
  logic            pop_valid_q, pop_valid_d;
  logic [W-1:0]    pop_data_q, pop_data_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_unf_q, err_unf_d;
  logic            bin_q, bin_d;
  logic [2:0]      fn_q, fn_d;
  logic            arg_q, arg_d;
  logic [W-1:0]    rd_data_q;
  logic [W-1:0]    mem_q [c_rw];

  logic            w_push_req;
  logic [W-1:0]    w_push_val;
  logic            w_wr_en;
  logic            w_rd_en;
  logic [c_aw-1:0] w_wr_addr;
  logic [c_aw-1:0] w_rd_addr;

  // Old TOS spills to ram[depth-1]; NOS lives at ram[depth-2].
  assign w_wr_addr = c_aw'(depth_q - c_dw'(1));
  assign w_rd_addr = c_aw'(depth_q - c_dw'(2));

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    tos_d         = tos_q;
    pop_valid_d   = 1'b0;
    pop_data_d    = pop_data_q;
    err_ovf_d     = err_ovf_q;
    err_unf_d     = err_unf_q;
    bin_d         = bin_q;
    fn_d          = fn_q;
    arg_d         = arg_q;
    w_push_req    = 1'b0;
    w_push_val    = cmd_data_i;
    w_wr_en       = 1'b0;
    w_rd_en       = 1'b0;
    alu_a_o       = tos_q;
    alu_b_o       = tos_q;
    alu_fn_sel_o  = cmd_fn_i;
    alu_arg_cnt_o = cmd_arg_cnt_i;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_i)
            c_op_clr: begin
              err_ovf_d = 1'b0;
              err_unf_d = 1'b0;
            end
            c_op_push: w_push_req = 1'b1;
`ifdef STACK_DUP_EN
            c_op_dup: begin
              if (depth_q == '0) begin
                err_unf_d = 1'b1;
              end else begin
                w_push_req = 1'b1;
                w_push_val = tos_q;
              end
            end
`endif
            c_op_pop: begin
              if (depth_q == '0) begin
                err_unf_d = 1'b1;
              end else begin
                pop_data_d  = tos_q;
                pop_valid_d = 1'b1;
                depth_d     = depth_q - c_dw'(1);
                if (depth_q != c_dw'(1)) begin
                  state_d = S_LOAD;
                  bin_d   = 1'b0;
                  w_rd_en = 1'b1;
                end
              end
            end
            c_op_alu: begin
              if (!cmd_arg_cnt_i) begin
                if (depth_q == '0) err_unf_d = 1'b1;
                else               tos_d     = alu_q_i;
              end else if (depth_q < c_dw'(2)) begin
                err_unf_d = 1'b1;
              end else begin
                state_d = S_LOAD;
                bin_d   = 1'b1;
                fn_d    = cmd_fn_i;
                arg_d   = cmd_arg_cnt_i;
                w_rd_en = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        alu_a_o       = rd_data_q;
        alu_fn_sel_o  = fn_q;
        alu_arg_cnt_o = arg_q;
        state_d       = S_IDLE;
        if (bin_q) begin
          tos_d   = alu_q_i;
          depth_d = depth_q - c_dw'(1);
        end else begin
          tos_d = rd_data_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_push_req) begin
      if (depth_q == c_full) begin
        err_ovf_d = 1'b1;
      end else begin
        w_wr_en = (depth_q != '0);
        tos_d   = w_push_val;
        depth_d = depth_q + c_dw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      tos_q       <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      bin_q       <= 1'b0;
      fn_q        <= 3'b000;
      arg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      tos_q       <= tos_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      bin_q       <= bin_d;
      fn_q        <= fn_d;
      arg_q       <= arg_d;
    end
  end

  // Stack RAM: contents survive reset, read data registered at the accept edge.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[w_wr_addr] <= tos_q;
    if (w_rd_en) rd_data_q <= mem_q[w_rd_addr];
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign tos_o       = tos_q;
  assign depth_o     = depth_q;
  assign empty_o     = (depth_q == '0);
  assign full_o      = (depth_q == c_full);
  assign pop_valid_o = pop_valid_q;
  assign pop_data_o  = pop_data_q;
  assign err_ovf_o   = err_ovf_q;
  assign err_unf_o   = err_unf_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_alu_sequencer.sv
// ============================================================================
// Module     : tb_stack_alu_sequencer
// Description: Directed and random checks of stack_alu_sequencer against a
//              queue-based stack model with a toy 8-bit ALU attached.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_stack_alu_sequencer;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [2:0]    cmd_fn;
  logic          cmd_arg_cnt;
  logic [W-1:0]  alu_a, alu_b, alu_q;
  logic [2:0]    alu_fn_sel;
  logic          alu_arg_cnt;
  logic [W-1:0]  tos;
  logic [DW-1:0] depth;
  logic          empty, full, pop_valid, err_ovf, err_unf;
  logic [W-1:0]  pop_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b);
    case (fn)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign alu_q = alu_f(alu_fn_sel, alu_a, alu_b);

  stack_alu_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_data_i(cmd_data), .cmd_fn_i(cmd_fn), .cmd_arg_cnt_i(cmd_arg_cnt),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fn_sel_o(alu_fn_sel),
    .alu_arg_cnt_o(alu_arg_cnt), .alu_q_i(alu_q), .tos_o(tos), .depth_o(depth),
    .empty_o(empty), .full_o(full), .pop_valid_o(pop_valid), .pop_data_o(pop_data),
    .err_ovf_o(err_ovf), .err_unf_o(err_unf)
  );

  // Model: stk holds every valid entry (top last); m_tos is the visible TOS,
  // which may be stale once the stack drains to empty.
  logic [7:0] stk[$];
  logic [7:0] m_tos, m_pd, m_fn_l;
  logic       m_busy, m_bin, m_arg_l, m_pv, m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic predict();
    logic [7:0] r;
    if (rst) begin
      stk.delete();
      m_tos = 8'h00; m_busy = 1'b0; m_pv = 1'b0; m_pd = 8'h00;
      m_ovf = 1'b0;  m_unf = 1'b0;
      return;
    end
    m_pv = 1'b0;
    if (m_busy) begin
      m_busy = 1'b0;
      if (m_bin) begin
        r = alu_f(m_fn_l, stk[stk.size()-2], stk[stk.size()-1]);
        void'(stk.pop_back());
        void'(stk.pop_back());
        stk.push_back(r);
        m_tos = r;
      end else begin
        m_tos = stk[stk.size()-1];
      end
    end else if (cmd_valid) begin
      case (cmd_op)
        3'b000: begin m_ovf = 1'b0; m_unf = 1'b0; end
        3'b001: begin
          if (stk.size() == DEPTH) m_ovf = 1'b1;
          else begin stk.push_back(cmd_data); m_tos = cmd_data; end
        end
`ifdef STACK_DUP_EN
        3'b100: begin
          if (stk.size() == 0) m_unf = 1'b1;
          else if (stk.size() == DEPTH) m_ovf = 1'b1;
          else stk.push_back(m_tos);
        end
`endif
        3'b010: begin
          if (stk.size() == 0) m_unf = 1'b1;
          else begin
            m_pd = stk.pop_back();
            m_pv = 1'b1;
            if (stk.size() > 0) begin m_busy = 1'b1; m_bin = 1'b0; end
          end
        end
        3'b011: begin
          if (!cmd_arg_cnt) begin
            if (stk.size() == 0) m_unf = 1'b1;
            else begin
              r = alu_f(cmd_fn, m_tos, m_tos);
              stk[stk.size()-1] = r;
              m_tos = r;
            end
          end else if (stk.size() < 2) begin
            m_unf = 1'b1;
          end else begin
            m_busy = 1'b1; m_bin = 1'b1; m_fn_l = cmd_fn; m_arg_l = cmd_arg_cnt;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("ready", 32'(cmd_ready), 32'(!m_busy));
    chk("depth", 32'(depth), stk.size());
    chk("empty", 32'(empty), 32'(stk.size() == 0));
    chk("full", 32'(full), 32'(stk.size() == DEPTH));
    chk("tos", 32'(tos), 32'(m_tos));
    chk("pop_valid", 32'(pop_valid), 32'(m_pv));
    chk("pop_data", 32'(pop_data), 32'(m_pd));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_unf", 32'(err_unf), 32'(m_unf));
    if (!m_busy) begin
      chk("alu_a_idle", 32'(alu_a), 32'(m_tos));
      chk("alu_b_idle", 32'(alu_b), 32'(m_tos));
      chk("alu_fn_idle", 32'(alu_fn_sel), 32'(cmd_fn));
      chk("alu_arg_idle", 32'(alu_arg_cnt), 32'(cmd_arg_cnt));
    end else if (m_bin) begin
      chk("alu_a_load", 32'(alu_a), 32'(stk[stk.size()-2]));
      chk("alu_b_load", 32'(alu_b), 32'(m_tos));
      chk("alu_fn_load", 32'(alu_fn_sel), 32'(m_fn_l));
      chk("alu_arg_load", 32'(alu_arg_cnt), 32'(m_arg_l));
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [2:0] op,
                     input logic [7:0] d, input logic [2:0] fn, input logic arg);
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = d; cmd_fn = fn; cmd_arg_cnt = arg;
    predict();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_rst();
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0);
  endtask

  initial begin
    logic [2:0] op;
    int         x;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
    cmd_fn = 3'd0; cmd_arg_cnt = 1'b0;
    m_busy = 1'b0; m_bin = 1'b0; m_fn_l = 3'd0; m_arg_l = 1'b0;
    @(negedge clk);
    do_rst();
    do_rst();
    chk("lit_rst_depth", 32'(depth), 0);
    chk("lit_rst_tos", 32'(tos), 0);
    chk("lit_rst_ready", 32'(cmd_ready), 1);

    // Binary subtract: 5 - 3
    cyc(1'b0, 1'b1, 3'b001, 8'h05, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b001, 8'h03, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b011, 8'h00, 3'd1, 1'b1);
    chk("lit_bin_ready_low", 32'(cmd_ready), 0);
    cyc(1'b0, 1'b0, 3'b000, 8'h00, 3'd0, 1'b0);
    chk("lit_bin_tos", 32'(tos), 32'h02);
    chk("lit_bin_depth", 32'(depth), 1);
    chk("lit_bin_ready", 32'(cmd_ready), 1);

    // Unary invert of F0
    do_rst();
    cyc(1'b0, 1'b1, 3'b001, 8'hF0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b011, 8'h00, 3'd5, 1'b0);
    chk("lit_un_tos", 32'(tos), 32'h0F);
    chk("lit_un_depth", 32'(depth), 1);

    // Pop with reload
    do_rst();
    cyc(1'b0, 1'b1, 3'b001, 8'hAA, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b001, 8'hBB, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b010, 8'h00, 3'd0, 1'b0);
    chk("lit_pop_valid", 32'(pop_valid), 1);
    chk("lit_pop_data", 32'(pop_data), 32'hBB);
    cyc(1'b0, 1'b0, 3'b000, 8'h00, 3'd0, 1'b0);
    chk("lit_pop_tos", 32'(tos), 32'hAA);
    chk("lit_pop_depth", 32'(depth), 1);
    chk("lit_pop_pulse_end", 32'(pop_valid), 0);

    // Overflow
    do_rst();
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 3'b001, 8'(i + 1), 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b001, 8'h11, 3'd0, 1'b0);
    chk("lit_ovf_flag", 32'(err_ovf), 1);
    chk("lit_ovf_full", 32'(full), 1);
    chk("lit_ovf_tos", 32'(tos), DEPTH);
    cyc(1'b0, 1'b1, 3'b000, 8'h00, 3'd0, 1'b0);
    chk("lit_ovf_clr", 32'(err_ovf), 0);

    // Underflow
    do_rst();
    cyc(1'b0, 1'b1, 3'b010, 8'h00, 3'd0, 1'b0);
    chk("lit_unf_pop", 32'(err_unf), 1);
    chk("lit_unf_no_pulse", 32'(pop_valid), 0);
    cyc(1'b0, 1'b1, 3'b000, 8'h00, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b001, 8'h07, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b011, 8'h00, 3'd0, 1'b1);
    chk("lit_unf_bin", 32'(err_unf), 1);
    chk("lit_unf_tos", 32'(tos), 32'h07);
    chk("lit_unf_depth", 32'(depth), 1);

    // Reset during LOAD
    do_rst();
    cyc(1'b0, 1'b1, 3'b001, 8'h01, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b001, 8'h02, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b011, 8'h00, 3'd0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 8'h00, 3'd0, 1'b0);
    chk("lit_rstload_depth", 32'(depth), 0);
    chk("lit_rstload_tos", 32'(tos), 0);
    chk("lit_rstload_ready", 32'(cmd_ready), 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      x = int'($urandom_range(0, 15));
      if (x < 5)       op = 3'b001;
      else if (x < 8)  op = 3'b010;
      else if (x < 11) op = 3'b011;
      else if (x < 12) op = 3'b000;
      else if (x < 13) op = 3'b100;
      else             op = 3'($urandom_range(5, 7));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), op,
          8'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
